// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle RV32I core with valid/ready instruction and data ports
module multicycle_core #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter int          LED_WIDTH    = 6,
  parameter logic [4:0]  LED_REG      = 5'd10,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  output logic [2:0]           dmem_fn3,
  input  logic                 dmem_ready,
  input  logic [31:0]          dmem_rdata,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic                 halted
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t               state;
  logic [31:0]          pc;
  logic [31:0]          ir;
  logic [31:0]          a_q;
  logic [31:0]          b_q;
  logic [31:0]          imm_q;
  logic [31:0]          alu_q;
  logic [31:0]          npc_q;
  logic [31:0]          mdr;
  logic [31:0]          rf [32];
  logic                 imem_req_q;
  logic                 dmem_req_q;
  logic                 dmem_we_q;
  logic [LED_WIDTH-1:0] leds_q;
  logic                 retire_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 halted_q;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  fn3;
  logic        is_jal;
  logic        is_jalr;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        supported;
  logic [31:0] imm_d;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_y;
  logic        br_cond;
  logic [31:0] pc_plus4;
  logic [31:0] npc_d;
  logic [31:0] wb_data;
  logic        writes_rd;

  assign opcode    = ir[6:0];
  assign rd        = ir[11:7];
  assign fn3       = ir[14:12];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign supported = (opcode == OP_LUI) || (opcode == OP_AUIPC) || is_jal || is_jalr ||
                     is_branch || is_load || is_store || (opcode == OP_IMM) || (opcode == OP_OP);
  assign pc_plus4  = pc + 32'd4;
  assign writes_rd = !(is_branch || is_store);

  // Immediate generation from the latched instruction word
  always_comb begin
    imm_d = {{21{ir[31]}}, ir[30:20]};
    case (opcode)
      OP_LUI, OP_AUIPC: imm_d = {ir[31:12], 12'b0};
      OP_JAL:           imm_d = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_BRANCH:        imm_d = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_STORE:         imm_d = {{21{ir[31]}}, ir[30:25], ir[11:7]};
      default:          imm_d = {{21{ir[31]}}, ir[30:20]};
    endcase
  end

  // ALU: operand select then function select; non-arithmetic opcodes just add
  always_comb begin
    op_a = a_q;
    if ((opcode == OP_AUIPC) || is_jal || is_branch) op_a = pc;
    if (opcode == OP_LUI) op_a = 32'd0;
    op_b  = (opcode == OP_OP) ? b_q : imm_q;
    alu_y = op_a + op_b;
    if ((opcode == OP_OP) || (opcode == OP_IMM)) begin
      case (fn3)
        3'b000:  alu_y = ((opcode == OP_OP) && ir[30]) ? (op_a - op_b) : (op_a + op_b);
        3'b001:  alu_y = op_a << op_b[4:0];
        3'b010:  alu_y = {31'b0, ($signed(op_a) < $signed(op_b))};
        3'b011:  alu_y = {31'b0, (op_a < op_b)};
        3'b100:  alu_y = op_a ^ op_b;
        3'b101:  alu_y = ir[30] ? ($signed(op_a) >>> op_b[4:0]) : (op_a >> op_b[4:0]);
        3'b110:  alu_y = op_a | op_b;
        default: alu_y = op_a & op_b;
      endcase
    end
  end

  // Branch comparison on the rs1/rs2 operand registers
  always_comb begin
    case (fn3)
      3'b000:  br_cond = (a_q == b_q);
      3'b001:  br_cond = (a_q != b_q);
      3'b100:  br_cond = ($signed(a_q) < $signed(b_q));
      3'b101:  br_cond = ($signed(a_q) >= $signed(b_q));
      3'b110:  br_cond = (a_q < b_q);
      3'b111:  br_cond = (a_q >= b_q);
      default: br_cond = 1'b0;
    endcase
  end

  // Next PC (JALR drops bit 0) and write-back source select
  always_comb begin
    npc_d = pc_plus4;
    if ((is_branch && br_cond) || is_jal || is_jalr)
      npc_d = {alu_y[31:1], alu_y[0] & ~is_jalr};
    wb_data = alu_q;
    if (is_jal || is_jalr) wb_data = pc_plus4;
    else if (is_load)      wb_data = mdr;
  end

  // Main FSM: all architectural state commits in WB, and only if the next PC is aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_VECTOR;
      ir         <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      alu_q      <= '0;
      npc_q      <= '0;
      mdr        <= '0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      leds_q     <= '0;
      retire_q   <= 1'b0;
      count_q    <= '0;
      halted_q   <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir         <= imem_rdata;
            imem_req_q <= 1'b0;
            state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rf[rs1];
          b_q   <= rf[rs2];
          imm_q <= imm_d;
          if (!supported) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q <= alu_y;
          npc_q <= npc_d;
          if (is_load || is_store) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_store;
            state      <= S_MEM;
          end else begin
            retire_q <= ~npc_d[1];
            state    <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            mdr        <= dmem_rdata;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            retire_q   <= ~npc_q[1];
            state      <= S_WB;
          end
        end
        S_WB: begin
          if (retire_q) begin
            if (writes_rd && (rd != 5'd0)) begin
              rf[rd] <= wb_data;
              if (rd == LED_REG) leds_q <= wb_data[LED_WIDTH-1:0];
            end
            pc         <= npc_q;
            count_q    <= count_q + CNT_WIDTH'(1);
            retire_q   <= 1'b0;
            imem_req_q <= 1'b1;
            state      <= S_FETCH;
          end else begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          halted_q <= 1'b1;
          state    <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req     = imem_req_q & ~rst;
  assign imem_addr    = pc;
  assign dmem_req     = dmem_req_q & ~rst;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = alu_q;
  assign dmem_wdata   = b_q;
  assign dmem_fn3     = fn3;
  assign leds         = leds_q;
  assign retire       = retire_q;
  assign retire_count = count_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed-vector bench for multicycle_core
module tb_multicycle_core;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [2:0]  dmem_fn3;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [5:0]  leds;
  logic        retire;
  logic [3:0]  retire_count;
  logic        halted;

  multicycle_core #(
    .RESET_VECTOR(RV),
    .LED_WIDTH(6),
    .LED_REG(5'd10),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_fn3(dmem_fn3), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .leds(leds), .retire(retire), .retire_count(retire_count), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          dwait = 0;
  int          dcnt = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          ret_n = 0;
  int          rq[$];
  int          dreq_n = 0;
  int          unstable = 0;
  logic        prev_dreq = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic        prev_we = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_fn3 = '0;

  always @(posedge clk) cyc++;

  // Memory responders and retire monitor, all acting half a cycle after the active edge
  always @(negedge clk) begin
    if (imem_req) begin
      imem_ready = 1'b1;
      imem_rdata = imem[imem_addr[7:2]];
    end else begin
      imem_ready = 1'b0;
    end
    if (dmem_req) begin
      dreq_n++;
      if (prev_dreq && ((dmem_addr !== prev_addr) || (dmem_wdata !== prev_wdata) || (dmem_we !== prev_we)))
        unstable++;
      if (dcnt >= dwait) begin
        dmem_ready = 1'b1;
        if (dmem_we) begin
          dmem[dmem_addr[7:2]] = dmem_wdata;
          st_addr = dmem_addr;
          st_data = dmem_wdata;
          st_fn3  = dmem_fn3;
        end else begin
          dmem_rdata = dmem[dmem_addr[7:2]];
        end
      end else begin
        dmem_ready = 1'b0;
        dcnt++;
      end
    end else begin
      dmem_ready = 1'b0;
      dcnt = 0;
    end
    prev_dreq  = dmem_req;
    prev_addr  = dmem_addr;
    prev_wdata = dmem_wdata;
    prev_we    = dmem_we;
    if (retire) begin
      ret_n++;
      rq.push_back(cyc - t0 + 1);
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] r1,
                                        input logic [31:0] f3, input logic [31:0] rdn,
                                        input logic [6:0] op);
    return {imm[11:0], r1[4:0], f3[2:0], rdn[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] r2,
                                        input logic [31:0] r1, input logic [31:0] f3);
    return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] r2,
                                        input logic [31:0] r1, input logic [31:0] f3);
    return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rdn,
                                        input logic [6:0] op);
    return {imm20[19:0], rdn[4:0], op};
  endfunction

  function automatic int rq_at(input int i);
    return (i < rq.size()) ? rq[i] : -1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_assert();
    rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    t0       = cyc;
    ret_n    = 0;
    dreq_n   = 0;
    unstable = 0;
    rq.delete();
  endtask

  task automatic wait_retires(input int n, input int budget);
    for (int i = 0; i < budget && ret_n < n; i++) step();
  endtask

  int busy;

  initial begin
    // Reset state, then addi x10,x0,0x2A with zero-wait memory
    clear_mem();
    imem[0] = enc_i(32'h2A, 0, 0, 10, 7'h13);
    reset_assert();
    step();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_leds", leds, 0);
    chk("rst_count", retire_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    reset_release();
    step();
    chk("c1_imem_req", imem_req, 1);
    chk("c1_imem_addr", imem_addr, RV);
    wait_retires(1, 20);
    chk("addi_retired", ret_n, 1);
    chk("addi_retire_cycle", rq_at(0), 4);
    step();
    chk("addi_retire_fell", retire, 0);
    chk("addi_leds", leds, 6'h2A);
    chk("addi_count", retire_count, 1);
    chk("addi_next_addr", imem_addr, RV + 32'd4);

    // sw then lw with three data wait states
    clear_mem();
    imem[0] = enc_u(32'h80001, 6, 7'h37);
    imem[1] = enc_i(32'h37, 0, 0, 7, 7'h13);
    imem[2] = enc_s(32'd8, 7, 6, 2);
    imem[3] = enc_i(32'd8, 6, 2, 10, 7'h03);
    dwait = 3;
    reset_assert();
    reset_release();
    wait_retires(4, 100);
    chk("mem_retired", ret_n, 4);
    chk("sw_retire_cycle", rq_at(2), 16);
    chk("lw_retire_cycle", rq_at(3), 24);
    chk("mem_req_cycles", dreq_n, 8);
    chk("mem_stable", unstable, 0);
    chk("sw_addr", st_addr, 32'h8000_1008);
    chk("sw_data", st_data, 32'h37);
    chk("sw_fn3", st_fn3, 3'd2);
    step();
    chk("lw_leds", leds, 6'h37);
    dwait = 0;

    // beq x0,x0,-8 at 0x10 is taken, bne x0,x0,-8 falls through
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      for (int i = 0; i < 4; i++) imem[i] = enc_i(0, 0, 0, 0, 7'h13);
      imem[4] = enc_b(32'hFFFF_FFF8, 0, 0, (k == 0) ? 0 : 1);
      reset_assert();
      reset_release();
      wait_retires(5, 60);
      step();
      chk((k == 0) ? "beq_next_addr" : "bne_next_addr", imem_addr,
          (k == 0) ? 32'h8000_0008 : 32'h8000_0014);
    end

    // jalr to a misaligned target halts without retiring
    clear_mem();
    imem[0] = enc_u(32'h80000, 5, 7'h37);
    imem[1] = enc_i(32'h103, 5, 0, 5, 7'h13);
    imem[2] = enc_i(0, 5, 0, 1, 7'h67);
    reset_assert();
    reset_release();
    wait_retires(2, 40);
    repeat (5) step();
    chk("jalr_halted", halted, 1);
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req || dmem_req || retire) busy++;
    end
    chk("halt_quiet", busy, 0);
    chk("halt_count", retire_count, 2);
    chk("halt_retires", ret_n, 2);
    chk("halt_pc_kept", imem_addr, 32'h8000_0008);

    // Reset while a load waits for dmem_ready
    clear_mem();
    imem[0] = enc_i(32'd5, 0, 0, 10, 7'h13);
    imem[1] = enc_i(0, 0, 2, 11, 7'h03);
    dwait = 1000;
    reset_assert();
    reset_release();
    wait_retires(1, 20);
    for (int i = 0; i < 20 && !dmem_req; i++) step();
    chk("mrst_req_seen", dmem_req, 1);
    chk("mrst_count_before", retire_count, 1);
    step();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    chk("mrst_dmem_req_low", dmem_req, 0);
    chk("mrst_imem_req_low", imem_req, 0);
    reset_release();
    step();
    chk("mrst_pc", imem_addr, RV);
    chk("mrst_count", retire_count, 0);
    chk("mrst_leds", leds, 0);
    chk("mrst_fetch", imem_req, 1);
    dwait = 0;

    // 17 retirements wrap the 4-bit counter to 1
    clear_mem();
    for (int i = 0; i < 17; i++) imem[i] = enc_i(1, 10, 0, 10, 7'h13);
    reset_assert();
    reset_release();
    wait_retires(17, 200);
    step();
    chk("wrap_retired", ret_n, 17);
    chk("wrap_count", retire_count, 1);
    chk("wrap_leds", leds, 6'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
